// File: rtl/maze_lookup_arbiter_pkg.sv
// Shared definitions for the sprite movement FSMs, the maze lookup block and
// the lookup arbiter: direction codes, coordinate width, requester ids, FSM states.
package maze_lookup_arbiter_pkg;

  localparam int CW = 10;
  localparam int ID_W = 3;

  localparam logic [3:0] DIR_L    = 4'b1000;
  localparam logic [3:0] DIR_R    = 4'b0100;
  localparam logic [3:0] DIR_U    = 4'b0010;
  localparam logic [3:0] DIR_D    = 4'b0001;
  localparam logic [3:0] DIR_NONE = 4'b0000;

  localparam int ID_PACMAN = 0;
  localparam int ID_GHOST0 = 1;
  localparam int ID_GHOST1 = 2;
  localparam int ID_GHOST2 = 3;
  localparam int ID_GHOST3 = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } arb_state_e;

endpackage

// File: rtl/maze_lookup_arbiter_rr_priority_pick.sv
// Combinational round-robin picker: first set request at or above rr_ptr,
// wrapping modulo N_REQ.
module rr_priority_pick #(
  parameter int N_REQ = 5,
  parameter int IDX_W = 3
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] rr_ptr,
  output logic [N_REQ-1:0] win_onehot,
  output logic [IDX_W-1:0] win_idx,
  output logic             any_req
);

  logic [IDX_W-1:0] pos;

  always_comb begin
    win_onehot = '0;
    win_idx    = '0;
    any_req    = 1'b0;
    pos        = '0;
    // Walk offsets from farthest to nearest so the nearest set bit wins last.
    for (int i = N_REQ - 1; i >= 0; i--) begin
      pos = IDX_W'((int'(rr_ptr) + i) % N_REQ);
      if (req[pos]) begin
        win_idx = pos;
        any_req = 1'b1;
      end
    end
    win_onehot[win_idx] = any_req;
  end

endmodule

// File: rtl/maze_lookup_arbiter.sv
// Shares the single legal-moves maze lookup between Pac-Man and the ghosts:
// round-robin grant, registered lookup address, tagged legal-move response.
module maze_lookup_arbiter
  import maze_lookup_arbiter_pkg::*;
#(
  parameter int N_REQ      = 5,
  parameter int LOOKUP_LAT = 0,
  parameter int CW         = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [N_REQ-1:0]      req,
  input  logic [N_REQ*CW-1:0]   req_xpos,
  input  logic [N_REQ*CW-1:0]   req_ypos,
  input  logic [N_REQ*4-1:0]    req_dir,
  output logic [N_REQ-1:0]      gnt,
  output logic                  rsp_valid,
  output logic [2:0]            rsp_id,
  output logic [3:0]            rsp_moves,
  output logic [CW-1:0]         lk_xpos,
  output logic [CW-1:0]         lk_ypos,
  output logic [3:0]            lk_dir,
  input  logic [3:0]            lk_moves,
  output logic                  busy
);

  arb_state_e       state_q, state_d;
  logic [2:0]       rr_ptr_q, rr_ptr_d;
  logic [2:0]       win_id_q, win_id_d;
  logic [1:0]       cnt_q, cnt_d;
  logic [N_REQ-1:0] gnt_q, gnt_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic [2:0]       rsp_id_q, rsp_id_d;
  logic [3:0]       rsp_moves_q, rsp_moves_d;
  logic [CW-1:0]    lk_xpos_q, lk_xpos_d;
  logic [CW-1:0]    lk_ypos_q, lk_ypos_d;
  logic [3:0]       lk_dir_q, lk_dir_d;

  logic [N_REQ-1:0] pick_onehot;
  logic [2:0]       pick_idx;
  logic             pick_any;

  rr_priority_pick #(
    .N_REQ (N_REQ),
    .IDX_W (3)
  ) u_pick (
    .req        (req),
    .rr_ptr     (rr_ptr_q),
    .win_onehot (pick_onehot),
    .win_idx    (pick_idx),
    .any_req    (pick_any)
  );

  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    win_id_d    = win_id_q;
    cnt_d       = cnt_q;
    gnt_d       = '0;
    rsp_valid_d = 1'b0;
    rsp_id_d    = rsp_id_q;
    rsp_moves_d = rsp_moves_q;
    lk_xpos_d   = lk_xpos_q;
    lk_ypos_d   = lk_ypos_q;
    lk_dir_d    = lk_dir_q;
    case (state_q)
      ST_IDLE: begin
        if (pick_any) begin
          lk_xpos_d = req_xpos[pick_idx*CW +: CW];
          lk_ypos_d = req_ypos[pick_idx*CW +: CW];
          lk_dir_d  = req_dir[pick_idx*4 +: 4];
          gnt_d     = pick_onehot;
          win_id_d  = pick_idx;
          cnt_d     = 2'(LOOKUP_LAT);
          rr_ptr_d  = (pick_idx == 3'(N_REQ - 1)) ? 3'd0 : pick_idx + 3'd1;
          state_d   = ST_WAIT;
        end
      end
      ST_WAIT: begin
        // Count down the lookup latency; sample the mask only once it is valid.
        if (cnt_q != 2'd0) begin
          cnt_d = cnt_q - 2'd1;
        end else begin
          rsp_moves_d = lk_moves;
          rsp_id_d    = win_id_q;
          rsp_valid_d = 1'b1;
          state_d     = ST_RESP;
        end
      end
      ST_RESP: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      rr_ptr_q    <= '0;
      win_id_q    <= '0;
      cnt_q       <= '0;
      gnt_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= '0;
      rsp_moves_q <= '0;
      lk_xpos_q   <= '0;
      lk_ypos_q   <= '0;
      lk_dir_q    <= '0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      win_id_q    <= win_id_d;
      cnt_q       <= cnt_d;
      gnt_q       <= gnt_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_id_q    <= rsp_id_d;
      rsp_moves_q <= rsp_moves_d;
      lk_xpos_q   <= lk_xpos_d;
      lk_ypos_q   <= lk_ypos_d;
      lk_dir_q    <= lk_dir_d;
    end
  end

  assign gnt       = gnt_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_id    = rsp_id_q;
  assign rsp_moves = rsp_moves_q;
  assign lk_xpos   = lk_xpos_q;
  assign lk_ypos   = lk_ypos_q;
  assign lk_dir    = lk_dir_q;
  assign busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_maze_lookup_arbiter.sv
// Bench for maze_lookup_arbiter: three instances (lookup latency 0, 2, 3) with
// a latency-aware lookup stub and a transaction-level round-robin model.
module tb_maze_lookup_arbiter
  import maze_lookup_arbiter_pkg::*;
;
  localparam int N  = 5;
  localparam int NI = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [N-1:0]    req [NI];
  logic [N*CW-1:0] req_xpos [NI];
  logic [N*CW-1:0] req_ypos [NI];
  logic [N*4-1:0]  req_dir [NI];
  logic [N-1:0]    gnt [NI];
  logic            rsp_valid [NI];
  logic [2:0]      rsp_id [NI];
  logic [3:0]      rsp_moves [NI];
  logic [CW-1:0]   lk_xpos [NI];
  logic [CW-1:0]   lk_ypos [NI];
  logic [3:0]      lk_dir [NI];
  logic [3:0]      lk_moves [NI];
  logic            busy [NI];
  logic            ovr_en [NI];
  logic [3:0]      ovr_val [NI];

  int mptr [NI];
  int checks = 0;
  int passes = 0;

  function automatic int lat_of(int k);
    return (k == 0) ? 0 : k + 1;
  endfunction

  // Made-up maze: any deterministic function of the lookup address will do.
  function automatic logic [3:0] maze(logic [CW-1:0] x, logic [CW-1:0] y, logic [3:0] d);
    return {x[4] ^ y[1], x[2] ^ d[3], y[3] ^ x[0], d[0] ^ y[5] ^ x[7]};
  endfunction

  // Winner = pending requester with the smallest forward distance from the pointer.
  function automatic int rr_winner(logic [N-1:0] r, int ptr);
    int best = -1;
    int bestd = N;
    for (int i = 0; i < N; i++) begin
      if (r[i] && ((i - ptr + N) % N) < bestd) begin
        bestd = (i - ptr + N) % N;
        best  = i;
      end
    end
    return best;
  endfunction

  for (genvar g = 0; g < NI; g++) begin : gen_dut
    localparam int LAT = (g == 0) ? 0 : g + 1;
    logic [2*CW+3:0] seen = '0;
    int age = 0;
    int age_now;
    logic [3:0] good;

    maze_lookup_arbiter #(.N_REQ(N), .LOOKUP_LAT(LAT), .CW(CW)) u_dut (
      .clk(clk), .rst(rst), .req(req[g]), .req_xpos(req_xpos[g]), .req_ypos(req_ypos[g]),
      .req_dir(req_dir[g]), .gnt(gnt[g]), .rsp_valid(rsp_valid[g]), .rsp_id(rsp_id[g]),
      .rsp_moves(rsp_moves[g]), .lk_xpos(lk_xpos[g]), .lk_ypos(lk_ypos[g]), .lk_dir(lk_dir[g]),
      .lk_moves(lk_moves[g]), .busy(busy[g])
    );

    // Stub drives inverted (garbage) data until the address has been stable LAT cycles.
    assign age_now = ({lk_xpos[g], lk_ypos[g], lk_dir[g]} == seen) ? ((age >= 3) ? 3 : age + 1) : 0;
    assign good = ovr_en[g] ? ovr_val[g] : maze(lk_xpos[g], lk_ypos[g], lk_dir[g]);
    assign lk_moves[g] = (age_now >= LAT) ? good : ~good;
    always @(posedge clk) begin
      seen <= {lk_xpos[g], lk_ypos[g], lk_dir[g]};
      age  <= age_now;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    for (int k = 0; k < NI; k++) mptr[k] = 0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    for (int k = 0; k < NI; k++) begin
      checks++;
      if ({gnt[k], rsp_valid[k], rsp_id[k], rsp_moves[k], lk_xpos[k], lk_ypos[k], lk_dir[k], busy[k]} !== '0)
        $display("FAIL reset_outputs inst%0d: got %h expected 0", k,
                 {gnt[k], rsp_valid[k], rsp_id[k], rsp_moves[k], lk_xpos[k], lk_ypos[k], lk_dir[k], busy[k]});
      else passes++;
    end
    rst = 1'b0;
    for (int k = 0; k < NI; k++) mptr[k] = 0;
  endtask

  task automatic test_single();
    req_xpos[0][0 +: CW] = 10'd210;
    req_ypos[0][0 +: CW] = 10'd94;
    req_dir[0][3:0] = DIR_R;
    ovr_en[0] = 1'b1;
    ovr_val[0] = 4'b0101;
    req[0] = 5'b00001;
    checks++; if (busy[0] !== 1'b0) $display("FAIL single_idle_busy: got %b expected 0", busy[0]); else passes++;
    tick();
    checks++; if (gnt[0] !== 5'b00001) $display("FAIL single_gnt: got %b expected 00001", gnt[0]); else passes++;
    checks++; if (lk_xpos[0] !== 10'd210 || lk_ypos[0] !== 10'd94 || lk_dir[0] !== DIR_R)
      $display("FAIL single_lk: got %0d,%0d,%b expected 210,94,0100", lk_xpos[0], lk_ypos[0], lk_dir[0]); else passes++;
    checks++; if (busy[0] !== 1'b1 || rsp_valid[0] !== 1'b0)
      $display("FAIL single_t1_ctl: got busy=%b rsp_valid=%b expected 1,0", busy[0], rsp_valid[0]); else passes++;
    req[0] = '0;
    tick();
    checks++; if (gnt[0] !== '0) $display("FAIL single_gnt_clear: got %b expected 0", gnt[0]); else passes++;
    checks++; if (rsp_valid[0] !== 1'b1 || rsp_id[0] !== 3'd0 || rsp_moves[0] !== 4'b0101 || busy[0] !== 1'b1)
      $display("FAIL single_rsp: got v=%b id=%0d m=%b busy=%b expected 1,0,0101,1",
               rsp_valid[0], rsp_id[0], rsp_moves[0], busy[0]); else passes++;
    tick();
    checks++; if (rsp_valid[0] !== 1'b0 || busy[0] !== 1'b0 || rsp_moves[0] !== 4'b0101)
      $display("FAIL single_after: got v=%b busy=%b m=%b expected 0,0,0101", rsp_valid[0], busy[0], rsp_moves[0]); else passes++;
    ovr_en[0] = 1'b0;
    mptr[0] = 1;
  endtask

  task automatic test_contention();
    int exp_ids[6] = '{1, 2, 4, 1, 2, 4};
    int got = 0;
    int last_cyc = 0;
    int id;
    do_reset();
    for (int i = 0; i < N; i++) begin
      req_xpos[0][i*CW +: CW] = CW'($urandom);
      req_ypos[0][i*CW +: CW] = CW'($urandom);
      req_dir[0][i*4 +: 4] = DIR_U;
    end
    req[0] = 5'b10110;
    for (int c = 1; c <= 40 && got < 6; c++) begin
      tick();
      if (gnt[0] !== '0) begin
        id = -1;
        for (int i = 0; i < N; i++) if (gnt[0][i]) id = i;
        checks++; if (!$onehot(gnt[0]) || id != exp_ids[got])
          $display("FAIL contention_id%0d: got gnt=%b expected id %0d", got, gnt[0], exp_ids[got]); else passes++;
        if (got > 0) begin
          checks++; if (c - last_cyc != 3)
            $display("FAIL contention_gap%0d: got %0d cycles expected 3", got, c - last_cyc); else passes++;
        end
        last_cyc = c;
        got++;
        if (got == 6) req[0] = '0;
      end
    end
    checks++; if (got != 6) $display("FAIL contention_count: got %0d grants expected 6", got); else passes++;
    req[0] = '0;
    tick(); tick(); tick();
    mptr[0] = 0;
  endtask

  task automatic test_lat2();
    req_xpos[1][3*CW +: CW] = 10'd300;
    req_ypos[1][3*CW +: CW] = 10'd77;
    req_dir[1][3*4 +: 4] = DIR_L;
    ovr_en[1] = 1'b1;
    ovr_val[1] = 4'b1010;
    req[1] = 5'b01000;
    tick();
    checks++; if (gnt[1] !== 5'b01000) $display("FAIL lat2_gnt: got %b expected 01000", gnt[1]); else passes++;
    req[1] = '0;
    tick();
    checks++; if (rsp_valid[1] !== 1'b0) $display("FAIL lat2_early_t2: got %b expected 0", rsp_valid[1]); else passes++;
    tick();
    checks++; if (rsp_valid[1] !== 1'b0 || rsp_moves[1] !== 4'b0000)
      $display("FAIL lat2_early_t3: got v=%b m=%b expected 0,0000", rsp_valid[1], rsp_moves[1]); else passes++;
    tick();
    checks++; if (rsp_valid[1] !== 1'b1 || rsp_moves[1] !== 4'b1010 || rsp_id[1] !== 3'd3)
      $display("FAIL lat2_rsp: got v=%b m=%b id=%0d expected 1,1010,3", rsp_valid[1], rsp_moves[1], rsp_id[1]); else passes++;
    tick();
    ovr_en[1] = 1'b0;
    mptr[1] = 4;
  endtask

  task automatic test_withdraw();
    logic bad = 1'b0;
    req_xpos[0][0 +: CW] = CW'($urandom);
    req_xpos[0][2*CW +: CW] = CW'($urandom);
    req[0] = 5'b00001;
    tick();
    checks++; if (gnt[0] !== 5'b00001) $display("FAIL withdraw_gnt0: got %b expected 00001", gnt[0]); else passes++;
    req[0] = 5'b00100;
    tick();
    checks++; if (rsp_valid[0] !== 1'b1 || rsp_id[0] !== 3'd0)
      $display("FAIL withdraw_rsp0: got v=%b id=%0d expected 1,0", rsp_valid[0], rsp_id[0]); else passes++;
    req[0] = '0;
    for (int c = 0; c < 6; c++) begin
      tick();
      if (gnt[0][2] !== 1'b0 || rsp_valid[0] !== 1'b0) bad = 1'b1;
    end
    checks++; if (bad !== 1'b0) $display("FAIL withdraw_quiet: got activity=%b expected 0", bad); else passes++;
    req[0] = 5'b00001;
    tick();
    checks++; if (gnt[0] !== 5'b00001) $display("FAIL withdraw_regnt: got %b expected 00001", gnt[0]); else passes++;
    req[0] = '0;
    tick();
    checks++; if (rsp_valid[0] !== 1'b1 || rsp_id[0] !== 3'd0)
      $display("FAIL withdraw_rsp1: got v=%b id=%0d expected 1,0", rsp_valid[0], rsp_id[0]); else passes++;
    tick();
    mptr[0] = 1;
  endtask

  task automatic test_reset_mid_wait();
    logic seen_v = 1'b0;
    req_xpos[2][2*CW +: CW] = 10'd513;
    req[2] = 5'b00100;
    tick();
    checks++; if (gnt[2] !== 5'b00100) $display("FAIL rstwait_gnt: got %b expected 00100", gnt[2]); else passes++;
    req[2] = '0;
    tick();
    rst = 1'b1;
    #1;
    checks++;
    if ({gnt[2], rsp_valid[2], rsp_id[2], rsp_moves[2], lk_xpos[2], lk_ypos[2], lk_dir[2], busy[2]} !== '0)
      $display("FAIL rstwait_async: got %h expected 0",
               {gnt[2], rsp_valid[2], rsp_id[2], rsp_moves[2], lk_xpos[2], lk_ypos[2], lk_dir[2], busy[2]});
    else passes++;
    tick();
    rst = 1'b0;
    for (int k = 0; k < NI; k++) mptr[k] = 0;
    for (int c = 0; c < 6; c++) begin
      if (rsp_valid[2] !== 1'b0) seen_v = 1'b1;
      tick();
    end
    checks++; if (seen_v !== 1'b0) $display("FAIL rstwait_no_rsp: got %b expected 0", seen_v); else passes++;
    req[2] = 5'b11111;
    tick();
    checks++; if (gnt[2] !== 5'b00001) $display("FAIL rstwait_first: got %b expected 00001", gnt[2]); else passes++;
    req[2] = '0;
    for (int c = 0; c < 5; c++) tick();
    mptr[2] = 1;
  endtask

  task automatic test_wrap();
    int exp_ids[3] = '{0, 4, 0};
    int got = 0;
    int last_cyc = 0;
    int id;
    req[0] = 5'b01000;
    tick();
    checks++; if (gnt[0] !== 5'b01000) $display("FAIL wrap_pre: got %b expected 01000", gnt[0]); else passes++;
    req[0] = '0;
    tick(); tick();
    req[0] = 5'b10001;
    tick();
    checks++; if (gnt[0] !== 5'b10000) $display("FAIL wrap_gnt4: got %b expected 10000", gnt[0]); else passes++;
    for (int c = 1; c <= 15 && got < 3; c++) begin
      tick();
      if (gnt[0] !== '0) begin
        id = -1;
        for (int i = 0; i < N; i++) if (gnt[0][i]) id = i;
        checks++; if (!$onehot(gnt[0]) || id != exp_ids[got] || c - last_cyc != 3)
          $display("FAIL wrap_seq%0d: got gnt=%b gap=%0d expected id %0d gap 3", got, gnt[0], c - last_cyc, exp_ids[got]);
        else passes++;
        last_cyc = c;
        got++;
        if (got == 3) req[0] = '0;
      end
    end
    checks++; if (got != 3) $display("FAIL wrap_count: got %0d grants expected 3", got); else passes++;
    req[0] = '0;
    tick(); tick(); tick();
    mptr[0] = 1;
  endtask

  task automatic test_random(int k, int rounds);
    int w;
    logic [CW-1:0] ex, ey;
    logic [3:0] ed;
    logic [N-1:0] eg;
    for (int r = 0; r < rounds; r++) begin
      for (int i = 0; i < N; i++) begin
        if (req[k][i]) begin
          if ($urandom_range(0, 9) < 3) req[k][i] = 1'b0;
        end else if ($urandom_range(0, 9) < 4) begin
          req[k][i] = 1'b1;
          req_xpos[k][i*CW +: CW] = CW'($urandom);
          req_ypos[k][i*CW +: CW] = CW'($urandom);
          req_dir[k][i*4 +: 4] = 4'($urandom);
        end
      end
      if (req[k] == '0) begin
        tick();
        checks++; if (gnt[k] !== '0 || busy[k] !== 1'b0)
          $display("FAIL rand%0d_idle: got gnt=%b busy=%b expected 0,0", k, gnt[k], busy[k]); else passes++;
        continue;
      end
      w = rr_winner(req[k], mptr[k]);
      ex = req_xpos[k][w*CW +: CW];
      ey = req_ypos[k][w*CW +: CW];
      ed = req_dir[k][w*4 +: 4];
      eg = N'(1) << w;
      tick();
      checks++; if (gnt[k] !== eg || busy[k] !== 1'b1)
        $display("FAIL rand%0d_gnt: got %b busy=%b expected %b,1", k, gnt[k], busy[k], eg); else passes++;
      checks++; if (lk_xpos[k] !== ex || lk_ypos[k] !== ey || lk_dir[k] !== ed)
        $display("FAIL rand%0d_lk: got %0d,%0d,%b expected %0d,%0d,%b", k, lk_xpos[k], lk_ypos[k], lk_dir[k], ex, ey, ed);
      else passes++;
      req[k][w] = 1'b0;
      mptr[k] = (w + 1) % N;
      for (int c = 0; c <= lat_of(k); c++) begin
        tick();
        checks++; if (rsp_valid[k] !== (c == lat_of(k)) || gnt[k] !== '0)
          $display("FAIL rand%0d_strobe: got v=%b gnt=%b at +%0d expected v=%b", k, rsp_valid[k], gnt[k], c, c == lat_of(k));
        else passes++;
      end
      checks++; if (rsp_id[k] !== 3'(w) || rsp_moves[k] !== maze(ex, ey, ed))
        $display("FAIL rand%0d_rsp: got id=%0d m=%b expected %0d,%b", k, rsp_id[k], rsp_moves[k], w, maze(ex, ey, ed));
      else passes++;
      tick();
      checks++; if (busy[k] !== 1'b0 || rsp_valid[k] !== 1'b0)
        $display("FAIL rand%0d_ret: got busy=%b v=%b expected 0,0", k, busy[k], rsp_valid[k]); else passes++;
    end
    req[k] = '0;
  endtask

  initial begin
    for (int k = 0; k < NI; k++) begin
      req[k] = '0;
      req_xpos[k] = '0;
      req_ypos[k] = '0;
      req_dir[k] = '0;
      ovr_en[k] = 1'b0;
      ovr_val[k] = '0;
      mptr[k] = 0;
    end
    test_reset();
    test_single();
    test_contention();
    test_lat2();
    test_withdraw();
    test_reset_mid_wait();
    test_wrap();
    for (int k = 0; k < NI; k++) test_random(k, 40);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/maze_lookup_arbiter.md
Name: maze_lookup_arbiter

Overview:
- Shares the single legal-moves maze lookup between Pac-Man and the ghosts.
- Each requester presents a pixel position and a direction. The arbiter picks one requester per transaction round-robin, drives the lookup address registers, and waits the lookup latency.
- It then returns the 4-bit legal-move mask, tagged with the requester id.
- Sits between the per-sprite movement FSMs and the maze lookup block.

Parameters:
- N_REQ, 5, number of requesters (index 0 = Pac-Man, 1..4 = ghosts); range 2..8.
- LOOKUP_LAT, 0, cycles from lk_xpos/lk_ypos/lk_dir stable to lk_moves valid; range 0..3 (0 = combinational lookup).
- CW, 10, coordinate width.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- req  in  N_REQ  per-requester request, level
- req_xpos  in  N_REQ*CW  packed x positions; requester i in bits [i*CW +: CW]
- req_ypos  in  N_REQ*CW  packed y positions, same packing
- req_dir  in  N_REQ*4  packed directions {L,R,U,D}, one-hot or zero
- gnt  out  N_REQ  one-hot grant pulse, registered
- rsp_valid  out  1  one-cycle response strobe
- rsp_id  out  3  index of requester the response belongs to
- rsp_moves  out  4  legal-move mask {L,R,U,D}
- lk_xpos  out  CW  lookup address x, registered
- lk_ypos  out  CW  lookup address y, registered
- lk_dir  out  4  lookup direction, registered
- lk_moves  in  4  legal-move mask returned by the lookup
- busy  out  1  high whenever the state is not IDLE

Behaviour:
- Reset (async, rst=1), all values 0:
  - state=IDLE, rr_ptr=0, wait counter=0.
  - gnt, rsp_valid, rsp_id, rsp_moves, lk_xpos, lk_ypos, lk_dir, busy.
- States: IDLE, WAIT, RESP.
- IDLE, cycle T, with any req bit high:
  - Winner = first set req bit searching from rr_ptr upward, wrapping modulo N_REQ.
  - At the edge ending T:
    - lk_* <= winner's payload.
    - gnt[winner] <= 1, other gnt bits 0.
    - cnt <= LOOKUP_LAT.
    - rr_ptr <= (winner+1) mod N_REQ.
    - state <= WAIT.
  - With no req bit high, stay in IDLE and leave all registers unchanged.
- gnt is high for exactly cycle T+1. It is cleared on the next edge regardless of state.
- WAIT:
  - If cnt != 0: cnt decrements each cycle.
  - If cnt == 0: rsp_moves <= lk_moves, rsp_id <= winner, rsp_valid <= 1, state <= RESP.
- RESP: lasts exactly one cycle, with rsp_valid high. Then rsp_valid <= 0 and state <= IDLE.
- Timing: rsp_valid is high in cycle T+2+LOOKUP_LAT. A new arbitration is evaluated in cycle T+3+LOOKUP_LAT.
- Throughput: one lookup per LOOKUP_LAT+3 cycles.
- lk_* stay stable from T+1 until the next grant.
- rsp_moves and rsp_id hold their values until the next response.
- Requester contract:
  - Hold payload stable while req is high and gnt has not been seen.
  - Deassert req in the cycle after gnt.
  - A req still high on return to IDLE is treated as a new request. It competes at lowest priority because rr_ptr has advanced.
- Withdrawing req before gnt is legal: no grant and no response are issued.
- Payload changes after gnt are ignored, because lk_* are latched.
- lk_dir is passed through unchecked: zero or a non-one-hot value is forwarded as-is.
- Simultaneous requests: exactly one grant per transaction. No requester waits more than N_REQ-1 transactions.
- Reset asserted mid-transaction (WAIT or RESP): the transaction is abandoned with no rsp_valid. rr_ptr returns to 0.
- rr_ptr wraps from N_REQ-1 to 0.

Decomposition:
- Shared package (used by movement FSMs and the lookup block):
  - Direction constants: DIR_L=4'b1000, DIR_R=4'b0100, DIR_U=4'b0010, DIR_D=4'b0001, DIR_NONE=4'b0000.
  - Coordinate width CW=10.
  - Requester ids: ID_PACMAN=0, ID_GHOST0..3=1..4.
  - State enum for this FSM.
- Sub-module rr_priority_pick:
  - Combinational.
  - Inputs: req vector, rr_ptr.
  - Outputs: one-hot winner, winner index, any_req.
  - Reused later by the sprite-draw scheduler.

Test Plan:
- Single request, LOOKUP_LAT=0:
  - Stimulus: req=5'b00001, xpos=210, ypos=94, dir=DIR_R; stub lookup returns 4'b0101.
  - Response: gnt=00001 one cycle at T+1; lk_xpos=210, lk_ypos=94; rsp_valid at T+2 with rsp_id=0, rsp_moves=0101; busy high T+1..T+2.
- Contention: req=5'b10110 held continuously from reset.
  - Grants: 1, 2, 4, 1, 2, 4.
  - Each grant is exactly 3 cycles after the previous one.
  - No grant to 0 or 3.
- LOOKUP_LAT=2:
  - Stimulus: request from id 3; the stub drives lk_moves=1010 only from the second cycle after lk_* change.
  - Response: rsp_valid at T+4, rsp_moves=1010. rsp_moves must not sample garbage earlier.
- Withdraw: id 2 raises req while id 0 is mid-transaction, then drops it before the next IDLE.
  - No gnt[2] and no response for id 2.
  - The following req from id 0 alone is granted normally.
- Reset mid-WAIT (LOOKUP_LAT=3):
  - Assert rst one cycle after gnt.
  - All outputs read 0 asynchronously; no rsp_valid.
  - After release, req=11111 grants id 0 first.
- Wrap: with N_REQ=5, grant id 4 with req=10001 pending, then keep req=10001.
  - Next grants: 0, 4, 0 (pointer wraps).
